// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate response checker.
//   state_t       : sequencing FSM states
//   VEC_COUNT     : number of input vectors applied to a 2-input gate
//   CNT_W         : width of the settle countdown
//   expected_bit(): expected gate output for a vector index
package gate_check_pkg;

    localparam int VEC_COUNT = 4;
    localparam int CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Truth-table lookup: bit idx of the table is the expected output for {aa,bb}=idx
    function automatic logic expected_bit(input logic [VEC_COUNT-1:0] table_bits,
                                          input logic [1:0]           idx);
        return table_bits[idx];
    endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// Settle countdown for the gate response checker.
//   clk, reset_n : clock, synchronous active-low reset
//   load         : load the counter with value (takes priority over counting)
//   value        : countdown start value
//   expired      : counter has reached zero
// Counts down by one per cycle when not loading and saturates at zero.
module gate_settle_timer
    import gate_check_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             expired
);

    logic [CNT_W-1:0] count_r;

    // Countdown register: load, decrement, or hold at zero
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= value;
        end else if (count_r != {CNT_W{1'b0}}) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/gate_response_checker.sv
// Exhaustive functional checker for a 2-input combinational gate.
// Applies vectors 00,01,10,11 on aa/bb, waits SETTLE_CYCLES, samples yy and
// compares against TRUTH_TABLE[{aa,bb}].
//   clk, reset_n : clock, synchronous active-low reset
//   start        : request one check sequence (ignored while busy)
//   yy           : gate output, assumed synchronous to clk
//   aa, bb       : stimulus to the gate
//   busy         : sequence in progress
//   done         : one-cycle completion pulse
//   pass         : last sequence had no mismatch
//   fail_mask    : bit i set when vector i mismatched
// All outputs are registered. done and pass are registered decodes of the DONE
// state, so they appear on the edge that returns the FSM to IDLE.
module gate_response_checker
    import gate_check_pkg::*;
#(
    parameter logic [3:0] TRUTH_TABLE   = 4'b1001,
    parameter int         SETTLE_CYCLES = 5
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       yy,
    output logic       aa,
    output logic       bb,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [1:0]       LAST_IDX    = 2'(VEC_COUNT - 1);

    state_t     state_r, state_s;
    logic [1:0] idx_r, idx_s;
    logic [3:0] fail_mask_r, fail_mask_s;
    logic       pass_r, pass_s;
    logic       aa_r, aa_s;
    logic       bb_r, bb_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       load_s;
    logic       expired_s;

    gate_settle_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load_s),
        .value   (SETTLE_LOAD),
        .expired (expired_s)
    );

    // Next-state and output decode
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        fail_mask_s = fail_mask_r;
        pass_s      = pass_r;
        load_s      = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    fail_mask_s = 4'b0000;
                    pass_s      = 1'b0;
                    idx_s       = 2'd0;
                    state_s     = ST_DRIVE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                load_s  = 1'b1;
                state_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (expired_s) begin
                    state_s = ST_SAMPLE;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
            ST_SAMPLE: begin
                if (yy != expected_bit(TRUTH_TABLE, idx_r)) begin
                    fail_mask_s[idx_r] = 1'b1;
                end else begin
                    fail_mask_s = fail_mask_r;
                end
                if (idx_r == LAST_IDX) begin
                    state_s = ST_DONE;
                end else begin
                    idx_s   = idx_r + 2'd1;
                    state_s = ST_DRIVE;
                end
            end
            ST_DONE: begin
                // fail_mask_r already includes the last vector's sample
                done_s  = 1'b1;
                pass_s  = (fail_mask_r == 4'b0000);
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Stimulus follows the upcoming state so aa/bb align with DRIVE..SAMPLE
        if ((state_s == ST_DRIVE) || (state_s == ST_SETTLE) || (state_s == ST_SAMPLE)) begin
            aa_s = idx_s[1];
            bb_s = idx_s[0];
        end else begin
            aa_s = 1'b0;
            bb_s = 1'b0;
        end
        busy_s = (state_s != ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= 2'd0;
            fail_mask_r <= 4'b0000;
            pass_r      <= 1'b0;
            aa_r        <= 1'b0;
            bb_r        <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            fail_mask_r <= fail_mask_s;
            pass_r      <= pass_s;
            aa_r        <= aa_s;
            bb_r        <= bb_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    assign aa        = aa_r;
    assign bb        = bb_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign pass      = pass_r;
    assign fail_mask = fail_mask_r;

endmodule

// File: doc/gate_response_checker.md
GATE_RESPONSE_CHECKER -- requirements
Module: gate_response_checker

Interface
REQ-001 The module SHALL have parameter TRUTH_TABLE, default 4'b1001, holding the expected yy for input vector index {aa,bb}; the default is XNOR.
REQ-002 The module SHALL have parameter SETTLE_CYCLES, default 5, giving the clock cycles a vector is held before yy is sampled; the legal range is 1..15.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The module SHALL have port start, input, 1 bit: request to run one full check sequence.
REQ-006 The module SHALL have port yy, input, 1 bit: output of the gate under test.
REQ-007 The module SHALL have port aa, output, 1 bit: first stimulus input to the gate under test.
REQ-008 The module SHALL have port bb, output, 1 bit: second stimulus input to the gate under test.
REQ-009 The module SHALL have port busy, output, 1 bit: high while a sequence is running.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse when a sequence ends.
REQ-011 The module SHALL have port pass, output, 1 bit: high when the last sequence had no mismatches.
REQ-012 The module SHALL have port fail_mask, output, 4 bits: bit i set when vector i mismatched.

Function
REQ-013 The FSM SHALL have states IDLE, DRIVE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE, start=1 SHALL clear fail_mask and pass, set vector index idx=0 and go to DRIVE; start=0 SHALL hold IDLE.
REQ-015 In DRIVE, the block SHALL present aa=idx[1] and bb=idx[0], load the settle counter with SETTLE_CYCLES-1 and go to SETTLE.
REQ-016 In SETTLE, the counter SHALL decrement once per cycle; at 0 the FSM SHALL go to SAMPLE.
REQ-017 In SAMPLE, yy SHALL be compared with TRUTH_TABLE[idx], and any mismatch SHALL set fail_mask[idx].
REQ-018 In SAMPLE with idx==3 the FSM SHALL go to DONE; otherwise idx SHALL increment and the FSM SHALL go to DRIVE.
REQ-019 aa and bb SHALL remain stable from DRIVE through SAMPLE for each vector, and SHALL be 0 in IDLE and DONE.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, pass SHALL be set to (fail_mask==0) including the final sample, and the FSM SHALL return to IDLE.
REQ-021 busy SHALL be 1 in DRIVE, SETTLE, SAMPLE and DONE, and 0 in IDLE.
REQ-022 start SHALL be ignored while busy=1, including the DONE cycle, with no restart and no queuing.
REQ-023 pass and fail_mask SHALL hold their values after DONE until the next accepted start.
REQ-024 Latency SHALL be 4*(SETTLE_CYCLES+2)+1 cycles from the start-sampling edge to the edge asserting done, which is 29 cycles at the default SETTLE_CYCLES.
REQ-025 yy SHALL be treated as synchronous to clk, with no synchroniser inside the block.
REQ-026 The vector order SHALL be fixed as 00, 01, 10, 11, with idx as a 2-bit counter that never wraps within a sequence.

Reset
REQ-027 When reset_n=0 at a clock edge, the block SHALL enter IDLE with aa=0, bb=0, busy=0, done=0, pass=0, fail_mask=4'b0000, idx=0 and counter=0.
REQ-028 Reset asserted mid-sequence SHALL abort that sequence with no done pulse, and pass and fail_mask SHALL be cleared.
REQ-029 start SHALL be ignored during any cycle in which reset_n=0.

Structure
REQ-030 Package gate_check_pkg SHALL hold the FSM state enum, the constant VEC_COUNT=4 and the settle counter width of 4.
REQ-031 The settle countdown SHALL be one sub-module, gate_settle_timer, with load, value and expired.
REQ-032 All state SHALL live in a single clocked process; next-state and output decode SHALL be combinational.

Verification
REQ-033 With an XNOR model on yy, default parameters and a start pulse, the bench SHALL see done at cycle 29, pass=1 and fail_mask=0000.
REQ-034 With an XOR model on yy and TRUTH_TABLE=1001, the bench SHALL see pass=0 and fail_mask=1111.
REQ-035 With yy tied to 1 and TRUTH_TABLE=1001, the bench SHALL see fail_mask=0110 and pass=0.
REQ-036 With start held high for 40 cycles, the bench SHALL see exactly one sequence, then a second starting the cycle after DONE returns to IDLE.
REQ-037 With reset_n=0 at cycle 12 of a sequence, the bench SHALL see no done pulse, all outputs 0 and IDLE on the next cycle.
REQ-038 With SETTLE_CYCLES=1, the bench SHALL see each vector held for 3 cycles and done 13 cycles after start.
